// File: rtl/guy_move_ctrl.sv
// guy_move_ctrl - player sprite movement controller.
//
// Synchronizes and debounces the four raw active-low direction buttons,
// arbitrates them to one held direction (up > down > left > right, no
// preemption of a held direction), optionally gates moves that would leave
// the arena, and issues one update strobe every FRAMES_PER_STEP frames.
//
// Optional feature macro: GUY_MOVE_BOUNDS_EN
//   defined   - direction outputs are forced released when the move would
//               leave [0,X_MAX]x[0,Y_MAX]
//   undefined - no gating; pos_x/pos_y are unused
//
// Ports:
//   clk          system/pixel clock, rising edge
//   rst          asynchronous active-low reset
//   frame_start  one-cycle pulse per video frame
//   btn_*_n      raw buttons, active-low, asynchronous
//   pos_x/pos_y  current sprite position
//   up/down/left/right  active-low direction to sprite (at most one low)
//   update       one-cycle step strobe (cycle after the tick)
//   dir_held     arbiter state: 0 IDLE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT
module guy_move_ctrl #(
  parameter logic [15:0] DEB_CYCLES      = 16'd50000,
  parameter logic [7:0]  FRAMES_PER_STEP = 8'd2,
  parameter logic [9:0]  STEP            = 10'd3,
  parameter logic [9:0]  X_MAX           = 10'd625,
  parameter logic [8:0]  Y_MAX           = 9'd465
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic [9:0] pos_x,
  input  logic [8:0] pos_y,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       update,
  output logic [2:0] dir_held
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_LEFT  = 3'd3,
    S_RIGHT = 3'd4
  } state_t;

  localparam int NB = 4;  // bit 3 up, 2 down, 1 left, 0 right

  // Reset: asserts asynchronously, released to the logic synchronously.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Any reset assertion still clears everything immediately.
  logic rst_i;
  assign rst_i = rst_sync_q & rst;

  logic [NB-1:0]       btn_raw_n;
  logic [NB-1:0]       meta_q, sync_q;
  logic [NB-1:0]       deb_q, deb_d;
  logic [NB-1:0][15:0] cnt_q, cnt_d;

  assign btn_raw_n = {btn_up_n, btn_down_n, btn_left_n, btn_right_n};

  // Debounce: count consecutive cycles where the synced level disagrees
  // with the debounced level; flip on the DEB_CYCLES-th such cycle.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync_q[i] == deb_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] == DEB_CYCLES - 16'd1) begin
        cnt_d[i] = 16'd0;
        deb_d[i] = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
      deb_q  <= '1;
      cnt_q  <= '0;
    end else begin
      meta_q <= btn_raw_n;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  // Step tick from the frame counter.
  logic [7:0] fcnt_q, fcnt_d;
  logic       tick;

  always_comb begin
    fcnt_d = fcnt_q;
    tick   = 1'b0;
    if (frame_start) begin
      if (fcnt_q == FRAMES_PER_STEP - 8'd1) begin
        tick   = 1'b1;
        fcnt_d = 8'd0;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Arbiter.
  logic [NB-1:0] pressed;
  assign pressed = ~deb_q;

  function automatic state_t pick(input logic [NB-1:0] p);
    if      (p[3]) return S_UP;
    else if (p[2]) return S_DOWN;
    else if (p[1]) return S_LEFT;
    else if (p[0]) return S_RIGHT;
    else           return S_IDLE;
  endfunction

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_UP:    if (!pressed[3]) state_d = pick(pressed);
        S_DOWN:  if (!pressed[2]) state_d = pick(pressed);
        S_LEFT:  if (!pressed[1]) state_d = pick(pressed);
        S_RIGHT: if (!pressed[0]) state_d = pick(pressed);
        default: state_d = pick(pressed);
      endcase
    end
  end

  // Bounds gating: a set bit forces that direction released.
  logic [NB-1:0] block;
`ifdef GUY_MOVE_BOUNDS_EN
  always_comb begin
    block    = '0;
    block[3] = {1'b0, pos_y} < STEP;
    block[2] = {1'b0, pos_y} > ({1'b0, Y_MAX} - STEP);
    block[1] = pos_x < STEP;
    block[0] = pos_x > (X_MAX - STEP);
  end
`else
  logic unused_bounds;
  assign unused_bounds = ^{pos_x, pos_y, STEP, X_MAX, Y_MAX};
  assign block = '0;
`endif

  logic [NB-1:0] dir_n_q, dir_n_d;
  logic          update_q, update_d;

  always_comb begin
    dir_n_d  = dir_n_q;
    update_d = tick;
    if (tick) begin
      case (state_d)
        S_UP:    dir_n_d = 4'b0111;
        S_DOWN:  dir_n_d = 4'b1011;
        S_LEFT:  dir_n_d = 4'b1101;
        S_RIGHT: dir_n_d = 4'b1110;
        default: dir_n_d = 4'b1111;
      endcase
      dir_n_d = dir_n_d | block;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      fcnt_q   <= 8'd0;
      state_q  <= S_IDLE;
      dir_n_q  <= '1;
      update_q <= 1'b0;
    end else begin
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      dir_n_q  <= dir_n_d;
      update_q <= update_d;
    end
  end

  assign up       = dir_n_q[3];
  assign down     = dir_n_q[2];
  assign left     = dir_n_q[1];
  assign right    = dir_n_q[0];
  assign update   = update_q;
  assign dir_held = state_q;

endmodule
